// File: rtl/mreg_pkg.sv
// Shared constants and types for the micro register bank: destination map
// codes, access direction encodings and the init/run FSM state.
package mreg_pkg;

    localparam logic [3:0] MAP_SEL        = 4'h1;
    localparam logic [3:0] MAP_WDATA      = 4'h2;

    localparam logic       REG_FILE_READ  = 1'b0;
    localparam logic       REG_FILE_WRITE = 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mreg_stage.sv
// One channel's staging registers: a register select and a write word,
// loaded from the shared write bus when the map code targets them.
module mreg_stage
    import mreg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 4,
    parameter int CH_W       = 1,
    parameter int CH_IDX     = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  stage_en,
    input  logic [CH_W-1:0]       stage_ch,
    input  logic [3:0]            stage_dst,
    input  logic [DATA_WIDTH-1:0] shared_write_bus,
    output logic [ADDR_W-1:0]     sel,
    output logic [DATA_WIDTH-1:0] wdata
);

    logic                  w_hit;
    logic [ADDR_W-1:0]     r_sel;
    logic [DATA_WIDTH-1:0] r_wdata;

    assign w_hit = stage_en && (stage_ch == CH_W'(CH_IDX));

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sel   <= '0;
            r_wdata <= '0;
        end else if (w_hit) begin
            if (stage_dst == MAP_SEL)
                r_sel <= shared_write_bus[ADDR_W-1:0];
            else if (stage_dst == MAP_WDATA)
                r_wdata <= shared_write_bus;
        end
    end

    assign sel   = r_sel;
    assign wdata = r_wdata;

endmodule

// File: rtl/mreg_bank.sv
// Multi-channel micro register bank: per-channel staging, a valid/ready
// access port with a held read response, and a zero-fill after reset.
module mreg_bank
    import mreg_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 16,
    parameter  int NUM_CH     = 2,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  stage_en,
    input  logic [CH_W-1:0]       stage_ch,
    input  logic [3:0]            stage_dst,
    input  logic [DATA_WIDTH-1:0] shared_write_bus,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [CH_W-1:0]       acc_ch,
    input  logic                  acc_rw,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CH_W-1:0]       rd_ch,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_oor,
    output logic                  init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [NUM_CH-1:0][ADDR_W-1:0]     w_sel;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_wdata;
    logic [ADDR_W-1:0]                 w_acc_sel;
    logic [DATA_WIDTH-1:0]             w_acc_wdata;
    logic                              w_ch_ok;
    logic                              w_sel_oor;
    logic                              w_oor;
    logic                              w_acc_ready;
    logic                              w_fire;
    logic [DATA_WIDTH-1:0]             w_rd_word;

    state_t                            r_state, w_state_nxt;
    logic [ADDR_W-1:0]                 r_init_cnt, w_init_cnt_nxt;

    logic [DATA_WIDTH-1:0]             r_mem [DEPTH];
    logic                              r_rd_valid;
    logic [DATA_WIDTH-1:0]             r_rd_data;
    logic [CH_W-1:0]                   r_rd_ch;
    logic                              r_err_oor;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stage
        mreg_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (ADDR_W),
            .CH_W       (CH_W),
            .CH_IDX     (g)
        ) u_stage (
            .sys_clk          (sys_clk),
            .sys_reset_n      (sys_reset_n),
            .stage_en         (stage_en),
            .stage_ch         (stage_ch),
            .stage_dst        (stage_dst),
            .shared_write_bus (shared_write_bus),
            .sel              (w_sel[g]),
            .wdata            (w_wdata[g])
        );
    end

    // Channel mux; a channel index beyond NUM_CH flags as out of range.
    always_comb begin
        w_acc_sel   = '0;
        w_acc_wdata = '0;
        w_ch_ok     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_ch == CH_W'(i)) begin
                w_acc_sel   = w_sel[i];
                w_acc_wdata = w_wdata[i];
                w_ch_ok     = 1'b1;
            end
        end
    end

    // A power-of-two depth cannot be exceeded by an ADDR_W-bit select.
    if (DEPTH == (1 << ADDR_W)) begin : g_full_depth
        assign w_sel_oor = 1'b0;
    end else begin : g_part_depth
        assign w_sel_oor = (w_acc_sel > LAST_ADDR);
    end

    assign w_oor       = !w_ch_ok || w_sel_oor;
    assign w_acc_ready = (r_state == RUN) && (!r_rd_valid || rd_ready);
    assign w_fire      = acc_valid && w_acc_ready;
    assign w_rd_word   = w_oor ? '0 : r_mem[w_acc_sel];

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            INIT: begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt    = RUN;
                    w_init_cnt_nxt = '0;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Storage carries no reset; the fill defines it before RUN.
    always_ff @(posedge sys_clk) begin
        if (r_state == INIT)
            r_mem[r_init_cnt] <= '0;
        else if (w_fire && (acc_rw == REG_FILE_WRITE) && !w_oor)
            r_mem[w_acc_sel] <= w_acc_wdata;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_ch    <= '0;
            r_err_oor  <= 1'b0;
        end else begin
            r_err_oor <= w_fire && w_oor;
            if (w_fire && (acc_rw == REG_FILE_READ)) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= w_rd_word;
                r_rd_ch    <= acc_ch;
            end else if (rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign acc_ready = w_acc_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_ch     = r_rd_ch;
    assign err_oor   = r_err_oor;
    assign init_done = (r_state == RUN);

endmodule

// File: doc/mreg_bank.md
# mreg_bank

Parametrised micro register file succeeding the single-channel micro register file in the micro-sequencer datapath. Each of `NUM_CH` channels stages a register select and write data from the shared write bus using destination map codes. A valid/ready access port then reads or writes the storage array. After reset, an init sequencer zero-fills the array, and read responses are held under backpressure.

## Interface
- `DATA_WIDTH`, 16: word width and shared write bus width.
- `DEPTH`, 16: number of registers, >= 2; need not be a power of two.
- `NUM_CH`, 2: number of independent staging channels, >= 1.
- `ADDR_W`, `$clog2(DEPTH)`: derived; select width.
- `CH_W`, `max(1, $clog2(NUM_CH))`: derived; channel index width.
- `sys_clk` in 1: the single clock.
- `sys_reset_n` in 1: reset, asynchronous and active-low.
- `stage_en` in 1: staging write this cycle.
- `stage_ch` in `CH_W`: channel being staged.
- `stage_dst` in 4: destination map code.
- `shared_write_bus` in `DATA_WIDTH`: staging data.
- `acc_valid` in 1: access request.
- `acc_ready` out 1: access accepted when high together with `acc_valid`.
- `acc_ch` in `CH_W`: channel whose staged select and data are used.
- `acc_rw` in 1: `REG_FILE_READ` = 0, `REG_FILE_WRITE` = 1.
- `rd_valid` out 1: read response valid.
- `rd_ready` in 1: response consumer ready.
- `rd_ch` out `CH_W`: channel of the response.
- `rd_data` out `DATA_WIDTH`: read data.
- `err_oor` out 1: one-cycle pulse on an accepted access with select >= `DEPTH`.
- `init_done` out 1: high once the zero-fill has completed.

## Operation
- FSM states are `INIT` and `RUN`. Reset enters `INIT`.
- In `INIT`, a counter writes 0 to addresses 0..`DEPTH-1`, one per cycle. On the cycle that writes `DEPTH-1`, the FSM moves to `RUN`.
  - `acc_ready` is 0 throughout `INIT`.
  - Staging writes are accepted in `INIT`.
- Staging: when `stage_en` is high, the `stage_dst` code selects the target in channel `stage_ch`.
  - `MAP_SEL`: `sel[stage_ch]` takes `shared_write_bus[ADDR_W-1:0]`.
  - `MAP_WDATA`: `wdata[stage_ch]` takes `shared_write_bus`.
  - Any other code is ignored.
- Access: in `RUN`, `acc_ready` = `!rd_valid || rd_ready`.
  - An accepted write stores `wdata[acc_ch]` into `mem[sel[acc_ch]]`.
  - An accepted read loads `mem[sel[acc_ch]]` into `rd_data`, sets `rd_ch` to `acc_ch`, and sets `rd_valid`.
- Out of range: if `sel[acc_ch] >= DEPTH`, a write is dropped and a read returns 0 with `rd_valid` set. Either case pulses `err_oor`. `acc_ch >= NUM_CH` is treated the same way.
- Response hold: `rd_valid` clears when `rd_valid && rd_ready` and no new read is accepted that cycle. `rd_data` and `rd_ch` stay stable while `rd_valid && !rd_ready`.
- Reset values: `rd_valid` 0, `rd_data` 0, `rd_ch` 0, `err_oor` 0, `init_done` 0, `acc_ready` 0, all `sel` 0, all `wdata` 0. Array contents are defined only after `INIT`.

## Timing
- A staging write at edge N is visible to an access accepted at edge N+1 or later. An access accepted in the same cycle as a staging write to the same channel uses the pre-update values.
- Read latency is 1: an access accepted at edge N gives `rd_valid`/`rd_data` after edge N.
- A write accepted at edge N is readable by an access accepted at edge N+1.
- Back-to-back reads at full rate are allowed while `rd_ready` is held high.
- `INIT` lasts `DEPTH` cycles after reset deasserts. `init_done` rises, and `acc_ready` may rise, on the same edge as the transition to `RUN`.
- Reset asserted mid-operation immediately forces all outputs to their reset values. The fill restarts from address 0.

## Structure
- `mreg_pkg` holds:
  - map codes `MAP_SEL` = 4'h1 and `MAP_WDATA` = 4'h2;
  - `REG_FILE_READ` and `REG_FILE_WRITE`;
  - the FSM state enum `{INIT, RUN}`.
- Sub-module `mreg_stage` holds one channel's `sel`/`wdata` staging registers and their map decode. It is instantiated `NUM_CH` times with a generate loop.

## Test plan
- Reset, then idle with `DEPTH`=16 → `init_done` rises after 16 cycles. Reading address 5 returns 0.
- Channel 0: stage sel 3 and data 16'hBEEF, write, then read → `rd_data` = 16'hBEEF, `rd_ch` = 0, arriving 1 cycle after acceptance.
- Stage sel 2 / data 16'h1111 on channel 0 and sel 2 / data 16'h2222 on channel 1. Write channel 0, then channel 1, then read channel 0 → 16'h2222.
- Hold `rd_ready` low with a response pending → `acc_ready` goes 0 and `rd_data` stays stable. Raising `rd_ready` drains one response per cycle.
- `DEPTH`=12: stage sel 13 and write → `err_oor` pulses and no location changes. Reading sel 13 → `rd_data` 0, `err_oor` pulses.
- Assert `sys_reset_n` low mid-`INIT` and mid-read → outputs clear asynchronously, and the fill reruns the full `DEPTH` cycles.
